// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq (ALU_SEQ_FLAGS_EN adds flags)
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             cout;
`ifdef ALU_SEQ_FLAGS_EN
  logic [2:0]       flags;
`endif

  modport master (
    output in_valid, a, b, cin, sel, out_ready,
    input  in_ready, out_valid, res, res_hi, cout
`ifdef ALU_SEQ_FLAGS_EN
    , input flags
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sel, out_ready,
    output in_ready, out_valid, res, res_hi, cout
`ifdef ALU_SEQ_FLAGS_EN
    , output flags
`endif
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered eight-op ALU with iterative shift-add multiplier (ALU_SEQ_FLAGS_EN adds flags)
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             cout_q;
  logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
  logic [SHW:0]     cnt_q;
  logic [2:0]       flags_q;

  logic             in_ready, out_valid, accept, is_mul;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, step_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [SHW-1:0]   sh;

  assign accept = bus.in_valid && in_ready;
  assign is_mul = (bus.sel == OP_MUL);
  assign sh     = bus.b[SHW-1:0];

  // Extra top/bottom bit catches the carry, borrow or the last bit shifted out.
  assign add_w = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign sub_w = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
  assign shl_w = {1'b0, bus.a} << sh;
  assign shr_w = {bus.a, 1'b0} >> sh;

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        alu_res  = add_w[WIDTH-1:0];
        alu_cout = add_w[WIDTH];
        alu_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res  = sub_w[WIDTH-1:0];
        alu_cout = sub_w[WIDTH];
        alu_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res  = shl_w[WIDTH-1:0];
        alu_cout = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res  = shr_w[WIDTH:1];
        alu_cout = shr_w[0];
      end
      default: ;
    endcase
  end

  // One shift-add step: the multiplier drains out of lo_q as product bits fill it.
  assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign step_hi  = step_sum[WIDTH:1];
  assign step_lo  = {step_sum[0], lo_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = is_mul ? BUSY : DONE;
      BUSY: if (cnt_q == 1) state_d = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = is_mul ? BUSY : DONE;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      DONE: begin
        in_ready  = bus.out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q    <= '0;
      res_hi_q <= '0;
      cout_q   <= 1'b0;
      flags_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      if (is_mul) begin
        hi_q    <= '0;
        lo_q    <= bus.b;
        mcand_q <= bus.a;
        cnt_q   <= CNT_INIT;
      end else begin
        res_q    <= alu_res;
        res_hi_q <= '0;
        cout_q   <= alu_cout;
        flags_q  <= {alu_ovf, alu_res[WIDTH-1], alu_res == '0};
      end
    end else if (state_q == BUSY) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == 1) begin
        res_q    <= step_lo;
        res_hi_q <= step_hi;
        cout_q   <= 1'b0;
        flags_q  <= {1'b0, step_hi[WIDTH-1], {step_hi, step_lo} == '0};
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.res       = res_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.cout      = cout_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.flags     = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^flags_q;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (covers ALU_SEQ_FLAGS_EN when defined)
module tb_alu_seq;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] s, input logic [7:0] av,
                        input logic [7:0] bv, input logic c, input logic [7:0] er,
                        input logic [7:0] eh, input logic ec, input int ee);
    int n;
    int busy_rdy;
    bus.sel = s; bus.a = av; bus.b = bv; bus.cin = c;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    busy_rdy = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready) busy_rdy++;
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, ee);
    chk({tag, "_res"}, bus.res, er);
    chk({tag, "_hi"}, bus.res_hi, eh);
    chk({tag, "_cout"}, bus.cout, ec);
    if (ee > 1) chk({tag, "_busy_rdy"}, busy_rdy, 0);
  endtask

  initial begin
    int stale;
    checks = 0;
    errors = 0;
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.sel = 0; bus.out_ready = 0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_res", bus.res, 0);
    chk("rst_hi", bus.res_hi, 0);
    chk("rst_cout", bus.cout, 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("rst_flags", bus.flags, 0);
`endif
    rst_n = 1'b1;
    tick();

    run_op("add",     3'b000, 8'hF0, 8'h20, 1'b1, 8'h11, 8'h00, 1'b1, 1);
    run_op("add_wrap",3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    run_op("sub1",    3'b001, 8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 1'b1, 1);
    run_op("sub2",    3'b001, 8'h07, 8'h05, 1'b1, 8'h01, 8'h00, 1'b0, 1);
    run_op("and",     3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 1'b0, 1);
    run_op("or",      3'b011, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'h00, 1'b0, 1);
    run_op("xor",     3'b100, 8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 1'b0, 1);
    run_op("shl1",    3'b101, 8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 1'b1, 1);
    run_op("shr3",    3'b110, 8'h81, 8'h03, 1'b0, 8'h10, 8'h00, 1'b0, 1);
    run_op("shl0",    3'b101, 8'h5A, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0, 1);
    run_op("shl_hib", 3'b101, 8'h40, 8'h09, 1'b0, 8'h80, 8'h00, 1'b0, 1);
    run_op("shr7",    3'b110, 8'hC1, 8'h07, 1'b0, 8'h01, 8'h00, 1'b1, 1);
    run_op("mul_ff",  3'b111, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 9);
    run_op("mul_small",3'b111,8'h0D, 8'h0B, 1'b1, 8'h8F, 8'h00, 1'b0, 9);
    run_op("add_after_mul", 3'b000, 8'h01, 8'h02, 1'b0, 8'h03, 8'h00, 1'b0, 1);

    // Back-to-back: second bundle accepted while the first result retires.
    bus.sel = 3'b000; bus.a = 8'h10; bus.b = 8'h22; bus.cin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    chk("b2b_res1", bus.res, 8'h32);
    chk("b2b_rdy", bus.in_ready, 1);
    bus.sel = 3'b100; bus.a = 8'h0F; bus.b = 8'h03;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_valid2", bus.out_valid, 1);
    chk("b2b_res2", bus.res, 8'h0C);
    tick();

    // Backpressure: result holds while out_ready is low and new bundles are ignored.
    bus.sel = 3'b010; bus.a = 8'hF0; bus.b = 8'h3C; bus.cin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.sel = 3'b000; bus.a = 8'h11 + 8'(i); bus.b = 8'h77; bus.cin = 1'b1;
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_res", bus.res, 8'h30);
      chk("bp_cout", bus.cout, 0);
      chk("bp_rdy", bus.in_ready, 0);
      tick();
    end
    bus.sel = 3'b011; bus.a = 8'h0F; bus.b = 8'hF0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("bp_or_valid", bus.out_valid, 1);
    chk("bp_or_res", bus.res, 8'hFF);
    tick();
    chk("bp_idle_valid", bus.out_valid, 0);

    // Reset during the fourth multiply cycle discards the operation.
    bus.sel = 3'b111; bus.a = 8'h12; bus.b = 8'h34; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mrst_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_res", bus.res, 0);
    chk("mrst_hi", bus.res_hi, 0);
    chk("mrst_rdy", bus.in_ready, 1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) stale++;
      tick();
    end
    chk("mrst_stale", stale, 0);

`ifdef ALU_SEQ_FLAGS_EN
    run_op("flg_add", 3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1);
    chk("flg_add_flags", bus.flags, 3'b110);
    run_op("flg_zero", 3'b100, 8'h3C, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    chk("flg_zero_flags", bus.flags, 3'b001);
    run_op("flg_mul", 3'b111, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 9);
    chk("flg_mul_flags", bus.flags, 3'b010);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
